// File: rtl/score_pkg.sv
// Shared types and constants for the run-score path (tracker, scoreboard, top level).
package score_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OVER = 2'd2
  } state_e;

  localparam int SCORE_W       = 14;
  localparam int MAX_SCORE_DEF = 9999;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every DIV enabled cycles.
module tick_prescaler #(
  parameter int DIV = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins over enable, wrap after the last count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en & (cnt_q == LAST);

endmodule

// File: rtl/score_tracker.sv
// Run score generator: distance ticks plus coin bonuses, saturating, with session high score.
module score_tracker
  import score_pkg::*;
#(
  parameter int TICK_DIV    = 10_000_000,
  parameter int COIN_POINTS = 10,
  parameter int MAX_SCORE   = MAX_SCORE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               gameover,
  input  logic               coin,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_high,
  output logic               running,
  output logic               game_over
);

  state_e             state_q;
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] score_d;
  logic [SCORE_W-1:0] high_q;
  logic               new_high_q;
  logic               running_q;
  logic               game_over_q;
  logic               coin_q;

  logic in_run;
  logic run_entry;
  logic tick;
  logic pickup;

  assign in_run    = (state_q == S_RUN);
  assign run_entry = start & ~in_run;
  assign pickup    = coin & ~coin_q & in_run;

  // Add this cycle's points in a width one bit wider than the score, then clamp.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                 input logic t, input logic p);
    logic [SCORE_W:0] sum;
    sum = {1'b0, s} + (SCORE_W+1)'(t) + (p ? (SCORE_W+1)'(COIN_POINTS) : '0);
    if (sum > (SCORE_W+1)'(MAX_SCORE)) begin
      return SCORE_W'(MAX_SCORE);
    end
    return sum[SCORE_W-1:0];
  endfunction

  tick_prescaler #(
    .DIV(TICK_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (in_run),
    .clr (run_entry),
    .tick(tick)
  );

  assign score_d = sat_add(score_q, tick, pickup);

  // Coin level delayed by one cycle for rising-edge pickup detection, in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coin_q <= 1'b0;
    end else begin
      coin_q <= coin;
    end
  end

  // Run FSM with score accumulation, high-score capture and registered state decodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      score_q     <= '0;
      high_q      <= '0;
      new_high_q  <= 1'b0;
      running_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start) begin
            state_q     <= S_RUN;
            score_q     <= '0;
            new_high_q  <= 1'b0;
            running_q   <= 1'b1;
            game_over_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (gameover) begin
            // The ending cycle's tick/pickup is dropped; compare the frozen score.
            state_q     <= S_OVER;
            running_q   <= 1'b0;
            game_over_q <= 1'b1;
            if (score_q > high_q) begin
              high_q     <= score_q;
              new_high_q <= 1'b1;
            end
          end else begin
            score_q <= score_d;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          running_q   <= 1'b0;
          game_over_q <= 1'b0;
        end
      endcase
    end
  end

  assign score      = score_q;
  assign high_score = high_q;
  assign new_high   = new_high_q;
  assign running    = running_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker with a cycle-level reference model feeding a scoreboard queue.
module tb_score_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        gameover;
  logic        coin;
  logic [13:0] score;
  logic [13:0] high_score;
  logic        new_high;
  logic        running;
  logic        game_over;

  int tests = 0;
  int fails = 0;

  // Reference model state (0=IDLE, 1=RUN, 2=OVER)
  int m_state, m_cnt, m_score, m_high;
  bit m_nh, m_coinq;

  logic [30:0] exp_q[$];

  always #5 clk = ~clk;

  score_tracker #(
    .TICK_DIV   (4),
    .COIN_POINTS(10),
    .MAX_SCORE  (9999)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .gameover  (gameover),
    .coin      (coin),
    .score     (score),
    .high_score(high_score),
    .new_high  (new_high),
    .running   (running),
    .game_over (game_over)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_score = 0; m_high = 0; m_nh = 0; m_coinq = 0;
  endtask

  // Advance the reference model by one clock using the inputs currently applied.
  task automatic model_update();
    int s;
    bit tk, pk;
    case (m_state)
      0, 2: begin
        if (start) begin
          m_state = 1; m_score = 0; m_cnt = 0; m_nh = 0;
        end
      end
      default: begin
        if (gameover) begin
          m_state = 2;
          if (m_score > m_high) begin
            m_high = m_score; m_nh = 1;
          end
        end else begin
          tk = (m_cnt == 3);
          pk = coin && !m_coinq;
          s = m_score + (tk ? 1 : 0) + (pk ? 10 : 0);
          m_score = (s > 9999) ? 9999 : s;
          m_cnt = (m_cnt + 1) % 4;
        end
      end
    endcase
    m_coinq = coin;
  endtask

  // One clock: push the expected outputs, let the edge happen, pop and compare.
  task automatic step();
    logic [30:0] e;
    logic [30:0] o;
    model_update();
    exp_q.push_back({14'(m_score), 14'(m_high), m_nh, (m_state == 1), (m_state == 2)});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    o = {score, high_score, new_high, running, game_over};
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL cycle observed=%h expected=%h", o, e);
    end
  endtask

  task automatic coin_pulse();
    coin = 1'b1; step();
    coin = 1'b0; step();
  endtask

  task automatic pulse_start();
    start = 1'b1; step();
    start = 1'b0;
  endtask

  // Climb to exactly target using coins while far away and idle cycles near it.
  task automatic reach(input int target);
    int g = 0;
    while (m_score < target && g < 400) begin
      if (target - m_score >= 11) coin_pulse();
      else step();
      g++;
    end
    chk("reach", m_score, target);
  endtask

  // End the run on a cycle that would otherwise have produced a tick.
  task automatic end_on_tick();
    int g = 0;
    while (m_cnt != 3 && g < 8) begin
      step();
      g++;
    end
    gameover = 1'b1; step();
    gameover = 1'b0;
  endtask

  initial begin
    int s0;
    int g;
    rst = 1'b1; start = 1'b0; gameover = 1'b0; coin = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_score", score, 0);
    chk("rst_high", high_score, 0);
    chk("rst_flags", {new_high, running, game_over}, 0);
    rst = 1'b0;

    // gameover is ignored while idle
    gameover = 1'b1; step(); step();
    gameover = 1'b0;
    chk("idle_go_ignored", game_over, 0);

    // 1: forty cycles of running yields ten distance points
    pulse_start();
    repeat (40) step();
    chk("t1_score", score, 10);
    chk("t1_running", running, 1);
    chk("t1_game_over", game_over, 0);

    // start is ignored in RUN
    pulse_start();
    chk("start_in_run", running, 1);

    // 2: coin held high 20 cycles starting on a tick cycle
    g = 0;
    while (m_cnt != 3 && g < 8) begin step(); g++; end
    s0 = m_score;
    coin = 1'b1; step();
    chk("t2_tick_plus_coin", score, s0 + 11);
    repeat (19) step();
    chk("t2_held_once", score, s0 + 15);
    coin = 1'b0; step();

    // 3: saturation at the ceiling
    g = 0;
    while (m_score < 9990 && g < 2000) begin coin_pulse(); g++; end
    chk("t3_near_ceiling", (m_score >= 9990) ? 1 : 0, 1);
    coin_pulse();
    chk("t3_sat", score, 9999);
    repeat (3) coin_pulse();
    repeat (8) step();
    chk("t3_hold", score, 9999);

    // 4: fresh session, end at 37 on a tick cycle
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst2_score", score, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pulse_start();
    reach(37);
    end_on_tick();
    chk("t4_frozen", score, 37);
    chk("t4_game_over", game_over, 1);
    chk("t4_running", running, 0);
    chk("t4_high", high_score, 37);
    chk("t4_new_high", new_high, 1);
    repeat (6) step();
    chk("t4_still_frozen", score, 37);
    pulse_start();
    chk("t4_restart_score", score, 0);
    chk("t4_restart_nh", new_high, 0);
    chk("t4_restart_high", high_score, 37);

    // 5: equal score does not set new_high, a better one does
    reach(37);
    end_on_tick();
    chk("t5_equal_nh", new_high, 0);
    chk("t5_equal_high", high_score, 37);
    pulse_start();
    reach(52);
    end_on_tick();
    chk("t5_better_high", high_score, 52);
    chk("t5_better_nh", new_high, 1);

    // 6: asynchronous reset in the middle of a run
    pulse_start();
    reach(20);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("t6_score", score, 0);
    chk("t6_high", high_score, 0);
    chk("t6_flags", {new_high, running, game_over}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) step();
    chk("t6_stays_idle", running, 0);
    pulse_start();
    chk("t6_restart", running, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
